mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter for the single data-memory/MIO bus. It shares the bus between the CPU MEM-stage data port and a secondary bus master (DMA/display fetch engine). It serialises transfers with a req/ready handshake, returns read data and completion pulses to each master, and drives the CPU stall request while a CPU access is outstanding. It sits between the pipeline's MEM-stage memory port and the external RAM/MIO bus, and replaces the direct CPU-to-bus connection.

## Interface
- TIMEOUT, 255, cycles a granted transfer may wait for bus_ready before it is aborted (1..255)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held stable until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_done=1 and held until the next CPU completion
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle pulse with cpu_done when the access timed out
- cpu_stall  out  1  stall request to the pipeline
- dev_req, dev_we, dev_addr, dev_wdata, dev_rdata, dev_done, dev_err: same widths and meaning as the cpu_* ports, for the secondary master
- bus_req  out  1  bus transfer strobe
- bus_we  out  1  bus write enable
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data, sampled when bus_ready=1
- bus_ready  in  1  slave completion (MIO_ready)

## Operation
- State machine: IDLE, XFER, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the master not granted last (round-robin via last_grant register).
  - On grant: latch we/addr/wdata into the bus output registers, set bus_req=1, record the owner, clear the timeout counter, and go to XFER.
- XFER:
  - bus_req stays 1 and the bus outputs stay frozen.
  - When bus_ready=1:
    - Read: capture bus_rdata into the owner's rdata register.
    - Write: the owner's rdata register is unchanged.
    - Clear bus_req, set the owner's done, update last_grant, and go to DONE.
  - Otherwise increment the counter. When the counter equals TIMEOUT-1 with no ready:
    - Clear bus_req and go to DONE with the owner's done=1 and err=1.
    - On a timed-out read, owner rdata = 32'h0000_0000.
- DONE:
  - Lasts exactly one cycle; done/err are asserted.
  - No arbitration occurs in this cycle.
  - Next state is IDLE, with done/err cleared.
- Request handshake: masters must drop or change their request at the clock edge that ends the DONE cycle. A request still high in IDLE is treated as a new access.
- Stall: cpu_stall = cpu_req & ~cpu_done (combinational), so it deasserts in the DONE cycle.
- bus_ready is ignored outside XFER.
- Request inputs that change during XFER have no effect on the bus outputs.
- Reset (asynchronous, any state): state=IDLE, last_grant=dev (CPU wins the first tie). All outputs are 0: bus_*, *_done, *_err, *_rdata. cpu_stall then follows cpu_req.

## Timing
- Minimum access takes 3 cycles:
  - Cycle 0: IDLE grants.
  - Cycle 1: bus_req=1; ready sampled.
  - Cycle 2: done=1.
- Each cycle of slave wait adds one cycle.
- Maximum bus occupancy: TIMEOUT cycles in XFER plus 1 DONE cycle.
- Back-to-back: a new request in the cycle after DONE is granted in that cycle, so peak throughput is one transfer per 3 cycles.
- With both masters requesting continuously, grants strictly alternate. Worst-case CPU wait behind one device transfer is TIMEOUT+1 cycles.
- All outputs are registered except cpu_stall.

## Test plan
- Single CPU read, slave ready in the first XFER cycle:
  - Stimulus: cpu_req=1, cpu_we=0, addr=0x0000_0010, bus_rdata=0x1234_5678.
  - Required response: bus_req high for cycle 1 only, cpu_done in cycle 2, cpu_rdata=0x1234_5678, cpu_stall high in cycles 0-1 only.
- Simultaneous requests after reset, each with 2 wait cycles:
  - Stimulus: CPU write addr 0x4, data 0xAAAA_AAAA; device read addr 0x8.
  - Required response: CPU is served first (bus_we=1, bus_addr=4), cpu_done at cycle 4. Device is granted at cycle 5, dev_done at cycle 9. dev_* are idle and bus outputs are unchanged during the CPU transfer.
- Continuous requests from both masters for 6 transfers:
  - Required response: grant order CPU, dev, CPU, dev, CPU, dev; no master is granted twice in a row.
- Timeout: bus_ready never asserted, TIMEOUT=8.
  - Required response: bus_req drops after 8 XFER cycles. cpu_done=1 and cpu_err=1 in the same cycle, cpu_rdata=0. The next request is granted normally.
- Reset mid-transfer: assert rst low in cycle 2 of a device XFER (asynchronous, between clock edges).
  - Required response: bus_req, dev_done and dev_rdata go to 0 immediately. After release, a tie grants the CPU first.
- Ready outside XFER: bus_ready=1 while IDLE with no requests.
  - Required response: no done/err pulse and no rdata change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing the data-memory/MIO bus between the
// CPU MEM-stage port and a secondary (DMA/display) master.
package mem_bus_arbiter_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } busCmd_t;
endpackage

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_done,
    output logic              dev_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state, stateNext;
    busCmd_t           cmd, cmdNext, cpuCmd, devCmd;
    logic              busReq, busReqNext;
    logic              ownerDev, ownerDevNext;
    logic              lastDev, lastDevNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [DATA_W-1:0] cpuRdata, cpuRdataNext, devRdata, devRdataNext;
    logic              cpuDone, cpuDoneNext, cpuErr, cpuErrNext;
    logic              devDone, devDoneNext, devErr, devErrNext;
    logic              grantDev;
    logic              finish;

    assign cpuCmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign devCmd = '{we: dev_we, addr: dev_addr, wdata: dev_wdata};

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        stateNext    = state;
        cmdNext      = cmd;
        busReqNext   = busReq;
        ownerDevNext = ownerDev;
        lastDevNext  = lastDev;
        cntNext      = cnt;
        cpuRdataNext = cpuRdata;
        devRdataNext = devRdata;
        cpuDoneNext  = 1'b0;
        cpuErrNext   = 1'b0;
        devDoneNext  = 1'b0;
        devErrNext   = 1'b0;
        grantDev     = 1'b0;
        finish       = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_req || dev_req) begin
                    // On a tie the master not served last wins
                    grantDev     = dev_req && (!cpu_req || !lastDev);
                    cmdNext      = grantDev ? devCmd : cpuCmd;
                    ownerDevNext = grantDev;
                    busReqNext   = 1'b1;
                    cntNext      = '0;
                    stateNext    = XFER;
                end
            end
            XFER: begin
                finish = bus_ready || (cnt == CNT_W'(TIMEOUT - 1));
                if (finish) begin
                    busReqNext  = 1'b0;
                    lastDevNext = ownerDev;
                    stateNext   = DONE;
                    if (ownerDev) begin
                        devDoneNext = 1'b1;
                        devErrNext  = !bus_ready;
                        if (!cmd.we) devRdataNext = bus_ready ? bus_rdata : '0;
                    end else begin
                        cpuDoneNext = 1'b1;
                        cpuErrNext  = !bus_ready;
                        if (!cmd.we) cpuRdataNext = bus_ready ? bus_rdata : '0;
                    end
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmd      <= '0;
            busReq   <= 1'b0;
            ownerDev <= 1'b0;
            lastDev  <= 1'b1;
            cnt      <= '0;
            cpuRdata <= '0;
            devRdata <= '0;
            cpuDone  <= 1'b0;
            cpuErr   <= 1'b0;
            devDone  <= 1'b0;
            devErr   <= 1'b0;
        end else begin
            state    <= stateNext;
            cmd      <= cmdNext;
            busReq   <= busReqNext;
            ownerDev <= ownerDevNext;
            lastDev  <= lastDevNext;
            cnt      <= cntNext;
            cpuRdata <= cpuRdataNext;
            devRdata <= devRdataNext;
            cpuDone  <= cpuDoneNext;
            cpuErr   <= cpuErrNext;
            devDone  <= devDoneNext;
            devErr   <= devErrNext;
        end
    end

    assign bus_req   = busReq;
    assign bus_we    = cmd.we;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;
    assign cpu_rdata = cpuRdata;
    assign cpu_done  = cpuDone;
    assign cpu_err   = cpuErr;
    assign dev_rdata = devRdata;
    assign dev_done  = devDone;
    assign dev_err   = devErr;

    // Pipeline stall drops in the completion cycle so the MEM stage can advance
    assign cpu_stall = cpu_req & ~cpuDone;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of arbitration and latency.
module tb_mem_bus_arbiter;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_done, cpu_err, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dev_req, dev_we, dev_done, dev_err;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_done(dev_done), .dev_err(dev_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        cpu_req = 1'b1;
        rst = 1'b0;
        #2;
        nVec++;
        if ({bus_req, bus_we, bus_addr, bus_wdata} !== 66'h0) begin
            nErr++; $display("FAIL reset_bus: got %h want 0", {bus_req, bus_we, bus_addr, bus_wdata});
        end
        nVec++;
        if ({cpu_done, cpu_err, dev_done, dev_err, cpu_rdata, dev_rdata} !== 68'h0) begin
            nErr++; $display("FAIL reset_masters: got %h want 0", {cpu_done, cpu_err, dev_done, dev_err, cpu_rdata, dev_rdata});
        end
        nVec++;
        if (cpu_stall !== 1'b1) begin nErr++; $display("FAIL reset_stall_hi: got %b want 1", cpu_stall); end
        cpu_req = 1'b0;
        #1;
        nVec++;
        if (cpu_stall !== 1'b0) begin nErr++; $display("FAIL reset_stall_lo: got %b want 0", cpu_stall); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_wdata = '0;
        @(negedge clk);
        nVec++;
        if ({bus_req, cpu_done, cpu_stall} !== 3'b001) begin
            nErr++; $display("FAIL read_c0: got %b want 001", {bus_req, cpu_done, cpu_stall});
        end
        tick();
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        nVec++;
        if ({bus_req, bus_we, bus_addr, cpu_done, cpu_stall} !== {2'b10, 32'h0000_0010, 2'b01}) begin
            nErr++; $display("FAIL read_c1: got %h", {bus_req, bus_we, bus_addr, cpu_done, cpu_stall});
        end
        tick();
        bus_ready = 1'b0; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        nVec++;
        if ({bus_req, cpu_done, cpu_err, cpu_stall} !== 4'b0100) begin
            nErr++; $display("FAIL read_c2: got %b want 0100", {bus_req, cpu_done, cpu_err, cpu_stall});
        end
        nVec++;
        if (cpu_rdata !== 32'h1234_5678) begin nErr++; $display("FAIL read_data: got %h want 12345678", cpu_rdata); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        nVec++;
        if ({bus_req, cpu_done, cpu_stall, cpu_rdata} !== {3'b000, 32'h1234_5678}) begin
            nErr++; $display("FAIL read_c3: got %h", {bus_req, cpu_done, cpu_stall, cpu_rdata});
        end
        tick();
    endtask

    task automatic test_ready_idle();
        for (int c = 0; c < 4; c++) begin
            bus_ready = 1'b1;
            bus_rdata = $urandom | 32'h1;
            @(negedge clk);
            nVec++;
            if ({bus_req, cpu_done, cpu_err, dev_done, dev_err} !== 5'b0) begin
                nErr++; $display("FAIL idle_ready_pulse c%0d: got %b want 00000", c, {bus_req, cpu_done, cpu_err, dev_done, dev_err});
            end
            nVec++;
            if ({cpu_rdata, dev_rdata} !== {32'h1234_5678, 32'h0}) begin
                nErr++; $display("FAIL idle_ready_rdata c%0d: got %h want 1234567800000000", c, {cpu_rdata, dev_rdata});
            end
            tick();
        end
        bus_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic expReq, expDone;
        for (int c = 0; c <= int'(TO) + 1; c++) begin
            if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; end
            bus_ready = 1'b0;
            @(negedge clk);
            expReq  = (c >= 1) && (c <= int'(TO));
            expDone = (c == int'(TO) + 1);
            nVec++;
            if ({bus_req, cpu_done, cpu_err} !== {expReq, expDone, expDone}) begin
                nErr++; $display("FAIL timeout_c%0d: got %b want %b", c, {bus_req, cpu_done, cpu_err}, {expReq, expDone, expDone});
            end
            if (expDone) begin
                nVec++;
                if (cpu_rdata !== 32'h0) begin nErr++; $display("FAIL timeout_rdata: got %h want 0", cpu_rdata); end
            end
            tick();
        end
        cpu_req = 1'b0;
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 32'h30; dev_wdata = 32'h5555_5555;
        for (int c = 0; c < 3; c++) begin
            bus_ready = (c == 1);
            @(negedge clk);
            nVec++;
            if ({bus_req, dev_done, dev_err, cpu_done} !== {c == 1, c == 2, 2'b00}) begin
                nErr++; $display("FAIL after_timeout_c%0d: got %b", c, {bus_req, dev_done, dev_err, cpu_done});
            end
            if (c == 1) begin
                nVec++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 32'h30, 32'h5555_5555}) begin
                    nErr++; $display("FAIL after_timeout_cmd: got %h", {bus_we, bus_addr, bus_wdata});
                end
            end
            tick();
        end
        dev_req = 1'b0; bus_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic expReq;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4; cpu_wdata = 32'hAAAA_AAAA;
                dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h8; dev_wdata = 32'h0;
            end
            if (c == 5)  cpu_req = 1'b0;
            if (c == 10) dev_req = 1'b0;
            bus_ready = (c == 3) || (c == 8);
            bus_rdata = (c == 8) ? 32'hCAFE_F00D : $urandom;
            @(negedge clk);
            expReq = ((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 8));
            nVec++;
            if ({bus_req, cpu_done, dev_done, cpu_err, dev_err, cpu_stall} !== {expReq, c == 4, c == 9, 2'b00, c <= 3}) begin
                nErr++; $display("FAIL simul_c%0d: got %b want %b", c, {bus_req, cpu_done, dev_done, cpu_err, dev_err, cpu_stall},
                                 {expReq, c == 4, c == 9, 2'b00, c <= 3});
            end
            if (c >= 1 && c <= 3) begin
                nVec++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 32'h4, 32'hAAAA_AAAA}) begin
                    nErr++; $display("FAIL simul_cpu_cmd_c%0d: got %h", c, {bus_we, bus_addr, bus_wdata});
                end
            end
            if (c >= 6 && c <= 8) begin
                nVec++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b0, 32'h8, 32'h0}) begin
                    nErr++; $display("FAIL simul_dev_cmd_c%0d: got %h", c, {bus_we, bus_addr, bus_wdata});
                end
            end
            nVec++;
            if (dev_rdata !== ((c >= 9) ? 32'hCAFE_F00D : 32'h0)) begin
                nErr++; $display("FAIL simul_dev_rdata_c%0d: got %h", c, dev_rdata);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h40; end
            bus_ready = 1'b0;
            @(negedge clk);
            if (c == 2) begin
                nVec++;
                if (bus_req !== 1'b1) begin nErr++; $display("FAIL midrst_pre: got %b want 1", bus_req); end
            end
            if (c < 2) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        nVec++;
        if ({bus_req, dev_done, bus_addr, dev_rdata} !== 66'h0) begin
            nErr++; $display("FAIL midrst_async: got %h want 0", {bus_req, dev_done, bus_addr, dev_rdata});
        end
        tick();
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h1111_1111;
        for (int c = 0; c <= 5; c++) begin
            if (c == 3) cpu_req = 1'b0;
            bus_ready = (c == 1) || (c == 4);
            bus_rdata = (c == 4) ? 32'h0BAD_CAFE : 32'h0;
            @(negedge clk);
            nVec++;
            if ({bus_req, cpu_done, dev_done} !== {(c == 1) || (c == 4), c == 2, c == 5}) begin
                nErr++; $display("FAIL midrst_tie_c%0d: got %b", c, {bus_req, cpu_done, dev_done});
            end
            if (c == 1 || c == 4) begin
                nVec++;
                if ({bus_we, bus_addr} !== ((c == 1) ? {1'b1, 32'h44} : {1'b0, 32'h40})) begin
                    nErr++; $display("FAIL midrst_owner_c%0d: got %h", c, {bus_we, bus_addr});
                end
            end
            if (c == 5) begin
                nVec++;
                if (dev_rdata !== 32'h0BAD_CAFE) begin nErr++; $display("FAIL midrst_rdata: got %h want 0badcafe", dev_rdata); end
            end
            tick();
        end
        dev_req = 1'b0;
    endtask

    task automatic test_alternation();
        logic order [6];
        int   nG = 0;
        logic prevReq = 1'b0, prevCpuDone = 1'b0, prevDevDone = 1'b0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'h1;
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 32'h0000_1100; dev_wdata = 32'h2;
        bus_ready = 1'b1;
        for (int c = 0; c < 40 && nG < 6; c++) begin
            if (prevCpuDone) cpu_addr = cpu_addr + 32'h1;
            if (prevDevDone) dev_addr = dev_addr + 32'h1;
            @(negedge clk);
            if (bus_req && !prevReq) begin
                order[nG] = bus_addr[12];
                nG++;
            end
            prevReq = bus_req; prevCpuDone = cpu_done; prevDevDone = dev_done;
            tick();
        end
        nVec++;
        if (nG != 6) begin nErr++; $display("FAIL alt_count: got %0d want 6", nG); end
        for (int i = 0; i < nG; i++) begin
            nVec++;
            if (order[i] !== 1'(i % 2)) begin
                nErr++; $display("FAIL alt_order_%0d: got %b want %b", i, order[i], 1'(i % 2));
            end
        end
        quiet();
    endtask

    // Transaction-level reference: round-robin owner choice, latency arithmetic
    // from the slave's chosen wait count, and per-master held read data.
    task automatic test_random();
        bit          pend [2];
        logic        weM [2];
        logic [31:0] addrM [2], wdM [2], rdExp [2];
        bit          busy, lastDev, expErr, inXfer;
        int          own, gCyc, dCyc, rCyc, lat, r, prob;
        logic [31:0] capData;
        logic [3:0]  expFlags;
        logic        dn [2];
        do_reset();
        pend[0] = 0; pend[1] = 0; rdExp[0] = '0; rdExp[1] = '0;
        weM[0] = 0; weM[1] = 0; addrM[0] = '0; addrM[1] = '0; wdM[0] = '0; wdM[1] = '0;
        busy = 0; lastDev = 1; expErr = 0; own = 0; gCyc = 0; dCyc = 0; rCyc = -1; capData = '0;
        for (int t = 0; t < 2000; t++) begin
            prob = (t < 1000) ? 30 : 95;
            if (busy && t == dCyc + 1) begin
                pend[own] = 0;
                busy = 0;
            end
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 99) < prob) begin
                    pend[m] = 1; weM[m] = 1'($urandom_range(0, 1)); addrM[m] = $urandom; wdM[m] = $urandom;
                end
            end
            cpu_req = pend[0]; cpu_we = weM[0]; cpu_addr = addrM[0]; cpu_wdata = wdM[0];
            dev_req = pend[1]; dev_we = weM[1]; dev_addr = addrM[1]; dev_wdata = wdM[1];
            if (!busy && (pend[0] || pend[1])) begin
                own = (pend[1] && (!pend[0] || !lastDev)) ? 1 : 0;
                lastDev = (own == 1);
                busy = 1;
                gCyc = t;
                r = $urandom_range(0, 9);
                lat = (r == 0) ? int'(TO) : (r == 1) ? int'(TO) - 1 : $urandom_range(0, 3);
                if (lat < int'(TO)) begin
                    rCyc = t + 1 + lat; dCyc = t + 2 + lat; expErr = 0;
                end else begin
                    rCyc = -1; dCyc = t + 1 + int'(TO); expErr = 1;
                end
            end
            inXfer = busy && (t > gCyc) && (t < dCyc);
            bus_ready = inXfer ? (t == rCyc) : 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            if (inXfer && t == rCyc) capData = bus_rdata;
            @(negedge clk);
            dn[0] = busy && own == 0 && t == dCyc;
            dn[1] = busy && own == 1 && t == dCyc;
            if (busy && t == dCyc && !weM[own]) rdExp[own] = expErr ? 32'h0 : capData;
            expFlags = {dn[0], dn[0] & expErr, dn[1], dn[1] & expErr};
            nVec++;
            if ({cpu_done, cpu_err, dev_done, dev_err} !== expFlags) begin
                nErr++; $display("FAIL rnd_done t%0d: got %b want %b", t, {cpu_done, cpu_err, dev_done, dev_err}, expFlags);
            end
            nVec++;
            if (bus_req !== inXfer) begin nErr++; $display("FAIL rnd_busreq t%0d: got %b want %b", t, bus_req, inXfer); end
            if (inXfer) begin
                nVec++;
                if ({bus_we, bus_addr, bus_wdata} !== {weM[own], addrM[own], wdM[own]}) begin
                    nErr++; $display("FAIL rnd_cmd t%0d: got %h want %h", t, {bus_we, bus_addr, bus_wdata}, {weM[own], addrM[own], wdM[own]});
                end
            end
            nVec++;
            if ({cpu_rdata, dev_rdata} !== {rdExp[0], rdExp[1]}) begin
                nErr++; $display("FAIL rnd_rdata t%0d: got %h want %h", t, {cpu_rdata, dev_rdata}, {rdExp[0], rdExp[1]});
            end
            nVec++;
            if (cpu_stall !== (pend[0] && !dn[0])) begin
                nErr++; $display("FAIL rnd_stall t%0d: got %b want %b", t, cpu_stall, pend[0] && !dn[0]);
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        quiet();
        rst = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_ready_idle();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_alternation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
